// File: rtl/ffra_byte_seq.sv
// ffra_byte_seq: byte-serial front end for the 32-bit ffra adder core.
// Operands arrive one LANE-wide beat at a time and are assembled little-endian
// (first beat in the low lane). Full words go to ffra together. After LAT
// cycles of adder latency the result is captured and sent back one lane per
// beat.
//
// Ports
//   clk, rst                synchronous active-high reset
//   in_valid / in_ready     load-side handshake (in_ready high only in LOAD)
//   a_byte, b_byte, ci_byte operand lanes for the current load beat
//   a, b, ci                assembled words to ffra, held until the next load completes
//   o                       ffra result
//   out_valid / out_ready   unload-side handshake (out_valid high only in UNLOAD)
//   o_byte                  current result lane
//   busy                    high in WAIT or UNLOAD
//
// Build option FFRA_SEQ_PARITY_EN: adds one final unload beat carrying the XOR
// of all result lanes as captured.
//
// State table
//   ST_LOAD   | accept operand beats into the shadow registers
//   ST_WAIT   | words presented to ffra; count down the adder latency
//   ST_UNLOAD | stream captured result lanes out, LSB lane first

module ffra_byte_seq #(
  parameter int WIDTH = 32,
  parameter int LANE  = 8,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANE-1:0]  a_byte,
  input  logic [LANE-1:0]  b_byte,
  input  logic [LANE-1:0]  ci_byte,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] ci,
  input  logic [WIDTH-1:0] o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANE-1:0]  o_byte,
  output logic             busy
);

  localparam int BEATS = WIDTH / LANE;
`ifdef FFRA_SEQ_PARITY_EN
  localparam int OUT_BEATS = BEATS + 1;
`else
  localparam int OUT_BEATS = BEATS;
`endif
  localparam int BW = $clog2(BEATS + 1);
  localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [BW-1:0] LAST_IN  = BW'(BEATS - 1);
  localparam logic [BW-1:0] LAST_OUT = BW'(OUT_BEATS - 1);
  localparam logic [CW-1:0] LAT_INIT = CW'(LAT);

  typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_UNLOAD} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sha_q, sha_d, shb_q, shb_d, shc_q, shc_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ci_q, ci_d;
  logic [WIDTH-1:0] res_q, res_d;
`ifdef FFRA_SEQ_PARITY_EN
  logic [LANE-1:0]  par_q, par_d, par_x;

  always_comb begin
    par_x = '0;
    for (int i = 0; i < BEATS; i++) par_x = par_x ^ o[i*LANE +: LANE];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      beat_q  <= '0;
      cnt_q   <= '0;
      sha_q   <= '0;
      shb_q   <= '0;
      shc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ci_q    <= '0;
      res_q   <= '0;
`ifdef FFRA_SEQ_PARITY_EN
      par_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      shc_q   <= shc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ci_q    <= ci_d;
      res_q   <= res_d;
`ifdef FFRA_SEQ_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    shc_d   = shc_q;
    a_d     = a_q;
    b_d     = b_q;
    ci_d    = ci_q;
    res_d   = res_q;
`ifdef FFRA_SEQ_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          // New lane enters at the top, so the first beat ends up in the LSB lane.
          sha_d = {a_byte,  sha_q[WIDTH-1:LANE]};
          shb_d = {b_byte,  shb_q[WIDTH-1:LANE]};
          shc_d = {ci_byte, shc_q[WIDTH-1:LANE]};
          if (beat_q == LAST_IN) begin
            a_d     = sha_d;
            b_d     = shb_d;
            ci_d    = shc_d;
            cnt_d   = LAT_INIT;
            beat_d  = '0;
            state_d = ST_WAIT;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          res_d   = o;
`ifdef FFRA_SEQ_PARITY_EN
          par_d   = par_x;
`endif
          beat_d  = '0;
          state_d = ST_UNLOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_UNLOAD: begin
        if (out_ready) begin
          res_d = res_q >> LANE;
          if (beat_q == LAST_OUT) begin
            beat_d  = '0;
            state_d = ST_LOAD;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_UNLOAD);
  assign busy      = (state_q != ST_LOAD);
  assign a         = a_q;
  assign b         = b_q;
  assign ci        = ci_q;
`ifdef FFRA_SEQ_PARITY_EN
  // After BEATS shifts the result register is spent; the extra beat shows parity.
  assign o_byte = (state_q == ST_UNLOAD && beat_q == BW'(BEATS)) ? par_q : res_q[LANE-1:0];
`else
  assign o_byte = res_q[LANE-1:0];
`endif

endmodule

// File: tb/tb_ffra_byte_seq.sv
module tb_ffra_byte_seq;

`ifdef FFRA_SEQ_PARITY_EN
  localparam int OUTB = 5;
`else
  localparam int OUTB = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [3];
  logic        out_ready [3];
  logic [7:0]  a_byte    [3];
  logic [7:0]  b_byte    [3];
  logic [7:0]  ci_byte   [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        busy      [3];
  logic [7:0]  o_byte    [3];
  logic [31:0] a_o       [3];
  logic [31:0] b_o       [3];
  logic [31:0] ci_o      [3];

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] prev_a [3];

  always #5 clk = ~clk;

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    logic [31:0] o_w;
    ffra_byte_seq #(.WIDTH(32), .LANE(8), .LAT(L)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .a_byte(a_byte[g]), .b_byte(b_byte[g]), .ci_byte(ci_byte[g]),
      .a(a_o[g]), .b(b_o[g]), .ci(ci_o[g]), .o(o_w),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .o_byte(o_byte[g]),
      .busy(busy[g])
    );
    if (L == 0) begin : g_comb
      assign o_w = a_o[g] + b_o[g] + ci_o[g];
    end else begin : g_pipe
      logic [31:0] pipe [L];
      always_ff @(posedge clk) begin
        pipe[0] <= a_o[g] + b_o[g] + ci_o[g];
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign o_w = pipe[L-1];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_word(input int k, input logic [31:0] aw, input logic [31:0] bw,
                           input logic [31:0] cw, input int maxgap);
    for (int i = 0; i < 4; i++) begin
      int gap;
      gap = $urandom_range(0, maxgap);
      repeat (gap) begin
        in_valid[k] = 1'b0;
        tick();
        chk("gap_in_ready", 32'(in_ready[k]), 32'd1);
      end
      in_valid[k] = 1'b1;
      a_byte[k]   = aw[8*i +: 8];
      b_byte[k]   = bw[8*i +: 8];
      ci_byte[k]  = cw[8*i +: 8];
      chk("beat_in_ready", 32'(in_ready[k]), 32'd1);
      if (i == 3) chk("a_no_partial", a_o[k], prev_a[k]);
      tick();
    end
    in_valid[k] = 1'b0;
    chk("a_word", a_o[k], aw);
    chk("b_word", b_o[k], bw);
    chk("ci_word", ci_o[k], cw);
    chk("busy_after_load", 32'(busy[k]), 32'd1);
    chk("in_ready_after_load", 32'(in_ready[k]), 32'd0);
  endtask

  task automatic run_txn(input int k, input logic [31:0] aw, input logic [31:0] bw,
                         input logic [31:0] cw, input int maxgap, input int maxstall,
                         input bit junk, input int stall_at, input int stall_n);
    logic [31:0] sum;
    logic [7:0]  expb [5];
    int w;
    sum = aw + bw + cw;
    expb[4] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      expb[i] = sum[8*i +: 8];
      expb[4] = expb[4] ^ expb[i];
    end
    load_word(k, aw, bw, cw, maxgap);
    if (junk) begin
      in_valid[k] = 1'b1;
      a_byte[k] = 8'hFF; b_byte[k] = 8'hFF; ci_byte[k] = 8'hFF;
    end
    w = 0;
    while (!out_valid[k] && w < 20) begin
      w++;
      tick();
    end
    chk("wait_cycles", 32'(w), 32'(lat_of(k) + 1));
    for (int i = 0; i < OUTB; i++) begin
      int st;
      st = (i == stall_at) ? stall_n : int'($urandom_range(0, maxstall));
      repeat (st) begin
        out_ready[k] = 1'b0;
        tick();
        chk("stall_valid", 32'(out_valid[k]), 32'd1);
        chk("stall_byte", 32'(o_byte[k]), 32'(expb[i]));
      end
      out_ready[k] = 1'b1;
      chk("out_valid", 32'(out_valid[k]), 32'd1);
      chk("out_byte", 32'(o_byte[k]), 32'(expb[i]));
      chk("a_hold", a_o[k], aw);
      tick();
    end
    out_ready[k] = 1'b0;
    in_valid[k]  = 1'b0;
    chk("done_in_ready", 32'(in_ready[k]), 32'd1);
    chk("done_out_valid", 32'(out_valid[k]), 32'd0);
    chk("done_busy", 32'(busy[k]), 32'd0);
    chk("a_hold_after", a_o[k], aw);
    prev_a[k] = aw;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0;
      a_byte[k] = '0; b_byte[k] = '0; ci_byte[k] = '0;
      prev_a[k] = '0;
    end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", 32'(in_ready[k]), 32'd1);
      chk("rst_out_valid", 32'(out_valid[k]), 32'd0);
      chk("rst_busy", 32'(busy[k]), 32'd0);
      chk("rst_a", a_o[k], 32'd0);
      chk("rst_o_byte", 32'(o_byte[k]), 32'd0);
    end

    // Directed: basic load, then backpressure of 5 cycles on the third out beat.
    run_txn(0, 32'h12345678, 32'h11111111, 32'h0, 0, 0, 1'b0, -1, 0);
    run_txn(0, 32'h12345678, 32'h11111111, 32'h0, 0, 0, 1'b0, 2, 5);
    // Junk beats during WAIT/UNLOAD must not leak into the next load.
    run_txn(0, 32'h12345678, 32'h11111111, 32'h0, 0, 0, 1'b1, -1, 0);
    run_txn(0, 32'h00000001, 32'h0, 32'h0, 0, 0, 1'b1, -1, 0);

    // Reset after two load beats discards the partial shadows.
    in_valid[0] = 1'b1;
    a_byte[0] = 8'hEE; b_byte[0] = 8'hDD; ci_byte[0] = 8'hCC;
    tick();
    tick();
    in_valid[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_a", a_o[0], 32'd0);
    chk("mid_rst_b", b_o[0], 32'd0);
    chk("mid_rst_ci", ci_o[0], 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
    chk("mid_rst_busy", 32'(busy[0]), 32'd0);
    prev_a[0] = '0;
    run_txn(0, 32'hA1B2C3D4, 32'h01020304, 32'h0, 0, 0, 1'b0, -1, 0);

    // Directed latency variants.
    run_txn(1, 32'h12345678, 32'h11111111, 32'h0, 0, 0, 1'b0, -1, 0);
    run_txn(2, 32'h12345678, 32'h11111111, 32'h0, 0, 0, 1'b0, -1, 0);

    // Randomized transactions on all three latency variants.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 3; k++) begin
        run_txn(k, $urandom, $urandom, $urandom, 3, 3, 1'($urandom_range(0, 1)), -1, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ffra_byte_seq.md
Name: ffra_byte_seq

Overview:
- Byte-serial operand sequencer and result serializer wrapped around the 32-bit ffra adder core.
- The user project has only 8-bit pin lanes per operand, so this block:
  - assembles full-width a, b and ci words from byte beats on the pins;
  - presents those words stable to ffra;
  - waits out the adder latency;
  - captures o and streams it back out one byte per beat.
- Sits between the io_in/io_out pads and ffra inside user_project_wrapper.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of LANE.
- LANE, 8, byte-lane width per beat.
- LAT, 1, adder latency in clk cycles from operand change to valid o (0 = combinational).

Ports:
- clk  input  1  wb_clk_i domain clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  byte beat present on a_byte/b_byte/ci_byte.
- in_ready  output  1  block accepts a load beat this cycle.
- a_byte  input  LANE  operand A lane.
- b_byte  input  LANE  operand B lane.
- ci_byte  input  LANE  carry-in word lane.
- a  output  WIDTH  assembled operand A to ffra.
- b  output  WIDTH  assembled operand B to ffra.
- ci  output  WIDTH  assembled carry-in word to ffra.
- o  input  WIDTH  ffra result.
- out_valid  output  1  result byte present on o_byte.
- out_ready  input  1  consumer takes result byte.
- o_byte  output  LANE  result lane.
- busy  output  1  high in WAIT or UNLOAD.

Behaviour:
- Reset values:
  - State is LOAD.
  - Beat counter, shadow registers, a/b/ci, result register and o_byte are all 0.
  - out_valid is 0, busy is 0, in_ready is 1 in the first cycle after reset.
- BEATS = WIDTH/LANE (4 by default).
- Handshake on each side: transfer occurs when valid and ready are both high at the clk edge. in_ready and out_valid are pure functions of registered state.
- State machine:
  - LOAD (in_ready=1):
    - Each accepted beat shifts the three byte lanes into three shadow registers, little-endian: the first beat lands in [LANE-1:0], the last in the MSB lane.
    - On the BEATS-th accepted beat, shadows copy atomically into a/b/ci, the wait counter loads LAT, and the state goes to WAIT.
    - a/b/ci never show partial words.
  - WAIT (in_ready=0, busy=1):
    - Counter decrements each cycle.
    - In the WAIT cycle where counter==0, o is captured into the result register and the state goes to UNLOAD.
    - WAIT therefore lasts LAT+1 cycles.
  - UNLOAD (out_valid=1, busy=1):
    - o_byte = result[LANE-1:0].
    - Each accepted beat shifts the result right by LANE.
    - After BEATS accepted beats the state goes to LOAD, and in_ready is 1 in the next cycle.
- Stability and hold rules:
  - a/b/ci hold from load completion until the next load completes, including through UNLOAD and subsequent LOAD beats.
  - out_ready low in UNLOAD stalls indefinitely; o_byte is held stable.
  - in_valid outside LOAD is ignored and no data is lost into the shadows.
  - out_ready outside UNLOAD is ignored.
- Counters: beat counter is ceil(log2(BEATS+1)) bits, reset to 0 on each state entry; no wrap-around beyond BEATS.
- rst mid-operation (any state): synchronous return to reset values. Partial shadows are discarded and a/b/ci clear to 0.
- in_valid gaps during LOAD: the beat count is preserved and there is no timeout.

Optional Feature:
- Macro: FFRA_SEQ_PARITY_EN.
- Defined:
  - UNLOAD lasts BEATS+1 beats.
  - The extra final beat drives o_byte = XOR of all BEATS result lanes as captured; the parity is computed at capture time and held in a LANE-bit register.
- Undefined: UNLOAD is exactly BEATS beats, with no parity register or logic.

Test Plan:
- Basic load, LAT=1, bench stub o = registered a+b:
  - Stimulus: a bytes 78,56,34,12; b bytes 11,11,11,11; ci 0.
  - Response: a=0x12345678, b=0x11111111 one cycle after the 4th beat; WAIT 2 cycles; o_byte sequence 89,67,45,23; in_ready=1 the cycle after the last out beat.
- Backpressure: same stimulus with out_ready low 5 cycles mid-unload -> o_byte holds 45 throughout, sequence unchanged, no extra/missing beats.
- in_valid during WAIT/UNLOAD with bytes FF -> ignored; the next load of 01,00,00,00 yields a=0x00000001 exactly.
- rst asserted after 2 load beats -> next cycle a=b=ci=0, in_ready=1, busy=0; a fresh 4-beat load assembles correctly with no leftover bytes.
- LAT=0 with a combinational stub -> WAIT is 1 cycle and the captured result is correct; LAT=3 -> WAIT is 4 cycles.
- FFRA_SEQ_PARITY_EN defined, first scenario -> five out beats 89,67,45,23,88; undefined -> four beats only.
